// File: rtl/adc_driver.sv
// Dual-channel 14-bit ADC capture with latency-compensated alignment to the DAC launch strobe.
// Optional block averaging is compiled in with the ADC_AVG_EN macro.
module adc_driver #(
  parameter int ADC_LATENCY   = 7,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOG2_AVG      = 2
) (
  input  logic        CLK_65,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] ptos_x_ciclo,
  input  logic        data_valid_in,
  input  logic [13:0] ADC_DA,
  input  logic [13:0] ADC_DB,
  input  logic        ADC_OTR_A,
  input  logic        ADC_OTR_B,
  output logic        ADC_CLK_A,
  output logic        ADC_CLK_B,
  output logic        ADC_OEB_A,
  output logic        ADC_OEB_B,
  output logic [13:0] data_a,
  output logic [13:0] data_b,
  output logic        data_valid,
  output logic        cycle_end,
  output logic        otr_sticky,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, RUN = 2'd2} state_t;

  localparam int VDEPTH = ADC_LATENCY + 2;

  state_t            st;
  logic [13:0]       da1, da2, db1, db2;
  logic              oa1, oa2, ob1, ob2;
  logic [VDEPTH-1:0] vpipe;
  logic [15:0]       flush_cnt;
  logic [15:0]       sample_cnt;
  logic [15:0]       ptos_last;
  logic              tail;
  logic              emit;
  logic [13:0]       emit_a, emit_b;

  assign ADC_CLK_A = CLK_65;
  assign ADC_CLK_B = CLK_65;
  assign state     = st;
  assign tail      = vpipe[VDEPTH-1];
  assign ptos_last = (ptos_x_ciclo == 16'd0) ? 16'd0 : ptos_x_ciclo - 16'd1;

`ifdef ADC_AVG_EN
  localparam int AW = 14 + LOG2_AVG;
  localparam logic [LOG2_AVG:0] AVG_LAST = (LOG2_AVG + 1)'((1 << LOG2_AVG) - 1);

  logic [AW-1:0]     acc_a, acc_b, sum_a, sum_b;
  logic [LOG2_AVG:0] avg_cnt;

  assign sum_a  = acc_a + AW'(da2);
  assign sum_b  = acc_b + AW'(db2);
  assign emit   = tail && (avg_cnt == AVG_LAST);
  assign emit_a = sum_a[AW-1:LOG2_AVG];
  assign emit_b = sum_b[AW-1:LOG2_AVG];

  // Accumulators only live while running; any exit from RUN discards a partial block.
  always_ff @(posedge CLK_65) begin
    if (reset || !enable || st != RUN) begin
      acc_a   <= '0;
      acc_b   <= '0;
      avg_cnt <= '0;
    end else if (tail) begin
      if (emit) begin
        acc_a   <= '0;
        acc_b   <= '0;
        avg_cnt <= '0;
      end else begin
        acc_a   <= sum_a;
        acc_b   <= sum_b;
        avg_cnt <= avg_cnt + (LOG2_AVG + 1)'(1);
      end
    end
  end
`else
  assign emit   = tail;
  assign emit_a = da2;
  assign emit_b = db2;
`endif

  always_ff @(posedge CLK_65) begin
    if (reset) begin
      st         <= IDLE;
      da1        <= '0;
      da2        <= '0;
      db1        <= '0;
      db2        <= '0;
      oa1        <= 1'b0;
      oa2        <= 1'b0;
      ob1        <= 1'b0;
      ob2        <= 1'b0;
      vpipe      <= '0;
      flush_cnt  <= '0;
      sample_cnt <= '0;
      data_a     <= '0;
      data_b     <= '0;
      data_valid <= 1'b0;
      cycle_end  <= 1'b0;
      otr_sticky <= 1'b0;
      ADC_OEB_A  <= 1'b1;
      ADC_OEB_B  <= 1'b1;
    end else begin
      da1        <= ADC_DA;
      da2        <= da1;
      db1        <= ADC_DB;
      db2        <= db1;
      oa1        <= ADC_OTR_A;
      oa2        <= oa1;
      ob1        <= ADC_OTR_B;
      ob2        <= ob1;
      ADC_OEB_A  <= !enable;
      ADC_OEB_B  <= !enable;
      data_valid <= 1'b0;
      cycle_end  <= 1'b0;
      if (!enable) begin
        // Strobes still in flight are dropped: their samples belong to an aborted run.
        st         <= IDLE;
        vpipe      <= '0;
        sample_cnt <= '0;
        flush_cnt  <= '0;
      end else begin
        vpipe <= {vpipe[VDEPTH-2:0], data_valid_in && (st == RUN)};
        case (st)
          IDLE: begin
            st         <= FLUSH;
            flush_cnt  <= '0;
            otr_sticky <= 1'b0;
          end
          FLUSH: begin
            if (flush_cnt == 16'(SETTLE_CYCLES - 1)) st <= RUN;
            else flush_cnt <= flush_cnt + 16'd1;
          end
          RUN:     st <= RUN;
          default: st <= IDLE;
        endcase
        if (tail && (oa2 || ob2)) otr_sticky <= 1'b1;
        if (emit) begin
          data_a     <= emit_a;
          data_b     <= emit_b;
          data_valid <= 1'b1;
          // >= so a period length shrunk below the running count wraps on the next sample.
          if (sample_cnt >= ptos_last) begin
            cycle_end  <= 1'b1;
            sample_cnt <= '0;
          end else begin
            sample_cnt <= sample_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_driver.sv
// Randomized bench for adc_driver: a cycle-indexed reference model feeds an expected queue
// that a negedge monitor drains whenever the DUT presents data_valid.
module tb_adc_driver;
  localparam int L      = 7;
  localparam int SETTLE = 16;
  localparam int LOG2   = 2;
`ifdef ADC_AVG_EN
  localparam int NAVG = 1 << LOG2;
`else
  localparam int NAVG = 1;
`endif
  localparam int HN = 8192;

  logic        clk;
  logic        reset, enable, data_valid_in, ADC_OTR_A, ADC_OTR_B;
  logic [15:0] ptos_x_ciclo;
  logic [13:0] ADC_DA, ADC_DB;
  logic        ADC_CLK_A, ADC_CLK_B, ADC_OEB_A, ADC_OEB_B;
  logic [13:0] data_a, data_b;
  logic        data_valid, cycle_end, otr_sticky;
  logic [1:0]  state;

  adc_driver #(.ADC_LATENCY(L), .SETTLE_CYCLES(SETTLE), .LOG2_AVG(LOG2)) dut (
    .CLK_65(clk), .reset(reset), .enable(enable), .ptos_x_ciclo(ptos_x_ciclo),
    .data_valid_in(data_valid_in), .ADC_DA(ADC_DA), .ADC_DB(ADC_DB),
    .ADC_OTR_A(ADC_OTR_A), .ADC_OTR_B(ADC_OTR_B), .ADC_CLK_A(ADC_CLK_A),
    .ADC_CLK_B(ADC_CLK_B), .ADC_OEB_A(ADC_OEB_A), .ADC_OEB_B(ADC_OEB_B),
    .data_a(data_a), .data_b(data_b), .data_valid(data_valid),
    .cycle_end(cycle_end), .otr_sticky(otr_sticky), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, passes, cyc;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  // reference model state
  logic [13:0] hist_a[HN];
  logic [13:0] hist_b[HN];
  bit          hist_o[HN];
  int          run_len, mcount, grp_n, sum_a, sum_b, pend[$];
  int          exp_state;
  bit          otr_m, exp_sticky, exp_oeb, prev_en;
  logic [29:0] exp_q[$];
  int          exp_cyc_q[$];
  int          first_valid, last_valid_cyc;
  logic [13:0] last_a;

  task automatic emit_sample(input int c, input logic [15:0] ptos);
    int idx, eff;
    bit ce;
    logic [13:0] oa, ob;
    idx = (c - 2) % HN;
    if (hist_o[idx]) otr_m = 1'b1;
    sum_a += int'(hist_a[idx]);
    sum_b += int'(hist_b[idx]);
    grp_n++;
    if (grp_n == NAVG) begin
      oa  = 14'(sum_a / NAVG);
      ob  = 14'(sum_b / NAVG);
      eff = (ptos == 16'd0) ? 1 : int'(ptos);
      if (mcount >= eff - 1) begin ce = 1'b1; mcount = 0; end
      else begin ce = 1'b0; mcount++; end
      exp_q.push_back({otr_m, ce, oa, ob});
      exp_cyc_q.push_back(c + 1);
      grp_n = 0; sum_a = 0; sum_b = 0;
    end
  endtask

  // driver: one call per clock cycle, also advances the model
  task automatic drive(input bit rst, input bit en, input bit dvi, input logic [13:0] a,
                       input logic [13:0] b, input bit oa, input bit ob, input logic [15:0] ptos);
    @(posedge clk);
    #1;
    cyc++;
    check("adc_clk_hi", {ADC_CLK_A, ADC_CLK_B}, 2'b11);
    reset = rst; enable = en; data_valid_in = dvi; ADC_DA = a; ADC_DB = b;
    ADC_OTR_A = oa; ADC_OTR_B = ob; ptos_x_ciclo = ptos;
    hist_a[cyc % HN] = a; hist_b[cyc % HN] = b; hist_o[cyc % HN] = oa | ob;
    if (rst) begin
      run_len = 0; pend.delete(); mcount = 0; grp_n = 0; sum_a = 0; sum_b = 0;
      otr_m = 0; exp_sticky = 0; prev_en = 0; exp_state = 0; exp_oeb = 1;
      return;
    end
    exp_state  = (run_len == 0) ? 0 : (run_len <= SETTLE) ? 1 : 2;
    exp_sticky = otr_m;
    exp_oeb    = !prev_en;
    prev_en    = en;
    if (exp_state == 0 && en) otr_m = 1'b0;
    if (!en) begin
      pend.delete(); mcount = 0; grp_n = 0; sum_a = 0; sum_b = 0;
    end else if (pend.size() > 0 && pend[0] == cyc - (L + 2)) begin
      void'(pend.pop_front());
      emit_sample(cyc, ptos);
    end
    if (en && exp_state == 2 && dvi) pend.push_back(cyc);
    run_len = en ? run_len + 1 : 0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && cyc > 0) begin
      check("adc_clk_lo", {ADC_CLK_A, ADC_CLK_B}, 2'b00);
      check("state", state, exp_state);
      check("otr_sticky", otr_sticky, exp_sticky);
      check("oeb", {ADC_OEB_A, ADC_OEB_B}, {exp_oeb, exp_oeb});
      if (data_valid) begin
        if (first_valid < 0) first_valid = cyc;
        last_valid_cyc = cyc;
        last_a = data_a;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("valid_cycle", cyc, exp_cyc_q.pop_front());
          check("sample", {otr_sticky, cycle_end, data_a, data_b}, exp_q.pop_front());
        end
      end else begin
        check("cycle_end_idle", cycle_end, 0);
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
          check("missed_valid", 0, 1);
          void'(exp_cyc_q.pop_front());
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [13:0] r14();
    return 14'($urandom_range(0, 16383));
  endfunction

  int r;
  bit en_r;
  logic [15:0] ptos_r;
  int avg_vals[4];

  initial begin
    checks = 0; passes = 0; cyc = 0; first_valid = -1; last_valid_cyc = -1; last_a = '0;
    reset = 1; enable = 0; data_valid_in = 0; ADC_DA = '0; ADC_DB = '0;
    ADC_OTR_A = 0; ADC_OTR_B = 0; ptos_x_ciclo = '0;

    // reset with random pins
    for (int i = 0; i < 3; i++)
      drive(1, 0, 1, r14(), r14(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'd3);
    @(negedge clk);
    check("rst_data_a", data_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_valid", data_valid, 0);
    check("rst_cycle_end", cycle_end, 0);
    check("rst_otr", otr_sticky, 0);
    check("rst_state", state, 0);
    check("rst_oeb", {ADC_OEB_A, ADC_OEB_B}, 2'b11);

    for (int i = 0; i < 2; i++) drive(0, 0, 0, r14(), r14(), 0, 0, 16'd4);

    // continuous strobes, period 4, then period 0
    r = cyc + 1;
    first_valid = -1;
    for (int i = 0; i < 60; i++) drive(0, 1, 1, r14(), r14(), 0, 0, 16'd4);
    check("first_valid_latency", first_valid - r, 27 + NAVG - 1);
    for (int i = 0; i < 12; i++) drive(0, 1, 1, r14(), r14(), 0, 0, 16'd0);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, r14(), r14(), 0, 0, 16'd0);

    // single strobe at relative cycle 100, ADC_DA = relative cycle index
    r = cyc + 1;
    for (int i = 0; i < 120; i++) drive(0, 1, (i == 100), 14'(i), r14(), 0, 0, 16'd0);
`ifndef ADC_AVG_EN
    check("single_valid_cycle", last_valid_cyc - r, 110);
    check("single_valid_data", last_a, 107);
`endif
    for (int i = 0; i < 2; i++) drive(0, 0, 0, r14(), r14(), 0, 0, 16'd0);

    // one-cycle OTR_B on an aligned sample, then clear by re-enable
    for (int i = 0; i < 60; i++) drive(0, 1, 1, r14(), r14(), 0, (i == 40), 16'd4);
    @(negedge clk);
    check("otr_latched", otr_sticky, 1);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, r14(), r14(), 0, 0, 16'd4);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, r14(), r14(), 0, 0, 16'd4);
    @(negedge clk);
    check("otr_cleared", otr_sticky, 0);

    // strobe in RUN, enable dropped three cycles later: nothing may emerge
    for (int i = 0; i < 20; i++) drive(0, 1, 0, r14(), r14(), 0, 0, 16'd4);
    drive(0, 1, 1, r14(), r14(), 0, 0, 16'd4);
    for (int i = 0; i < 2; i++) drive(0, 1, 0, r14(), r14(), 0, 0, 16'd4);
    for (int i = 0; i < 15; i++) drive(0, 0, 0, r14(), r14(), 0, 0, 16'd4);

`ifdef ADC_AVG_EN
    // four aligned samples 100, 101, 102, 105 average to 102
    avg_vals = '{100, 101, 102, 105};
    for (int i = 0; i < 40; i++)
      drive(0, 1, (i >= 20 && i < 24), (i >= 27 && i < 31) ? 14'(avg_vals[i - 27]) : r14(),
            r14(), 0, 0, 16'd0);
    check("avg_value", last_a, 102);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, r14(), r14(), 0, 0, 16'd0);
`endif

    // randomized traffic
    en_r = 1; ptos_r = 16'd3;
    for (int i = 0; i < 2000; i++) begin
      if (en_r) en_r = ($urandom_range(0, 299) != 0);
      else      en_r = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) ptos_r = 16'($urandom_range(0, 6));
      drive(0, en_r, 1'($urandom_range(0, 1)), r14(), r14(),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0), ptos_r);
    end
    for (int i = 0; i < 20; i++) drive(0, 0, 0, r14(), r14(), 0, 0, ptos_r);
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
